// File: rtl/axi4_slave_bram_if.sv
// AXI4 memory-mapped bus bundle for axi4_slave_bram.
// Carries the AW, W, B, AR and R channels. The clock and reset stay as plain module ports.
// The master modport drives the request side. The slave modport drives ready, response and
// read data.
interface axi4_slave_bram_if #(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32
);
    // Write address channel
    logic [C_S_AXI_ID_WIDTH-1:0]   awid;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                    awlen;
    logic                          awvalid;
    logic                          awready;
    // Write data channel
    logic [31:0]                   wdata;
    logic [3:0]                    wstrb;
    logic                          wlast;
    logic                          wvalid;
    logic                          wready;
    // Write response channel
    logic [C_S_AXI_ID_WIDTH-1:0]   bid;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;
    // Read address channel
    logic [C_S_AXI_ID_WIDTH-1:0]   arid;
    logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                    arlen;
    logic                          arvalid;
    logic                          arready;
    // Read data channel
    logic [C_S_AXI_ID_WIDTH-1:0]   rid;
    logic [31:0]                   rdata;
    logic [1:0]                    rresp;
    logic                          rlast;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output awid, awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_slave_bram.sv
// AXI4 slave that fronts an on-chip 32-bit word RAM.
// Independent write and read engines each allow one outstanding INCR burst of up to 256 beats.
// Ports:
//   aclk   - sole clock
//   areset - asynchronous, active-high reset; every output is 0 while it is asserted
//   s_axi  - AXI4 bus (slave modport)
// Addresses above the RAM window return DECERR. The RAM is not written for those bursts, and
// their read data is 0. The RAM contents are not reset.
module axi4_slave_bram #(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_MEM_DEPTH_LOG2   = 10
) (
    input logic              aclk,
    input logic              areset,
    axi4_slave_bram_if.slave s_axi
);
    localparam int unsigned MemDepth = 1 << C_MEM_DEPTH_LOG2;
    localparam int unsigned IdxW     = C_MEM_DEPTH_LOG2;

    typedef logic [IdxW-1:0]             idx_t;
    typedef logic [C_S_AXI_ID_WIDTH-1:0] id_t;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    // Set when any address bit at or above the RAM window is set.
    function automatic logic addr_decerr(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
        return (a >> (C_MEM_DEPTH_LOG2 + 2)) != '0;
    endfunction

    logic [31:0] mem [MemDepth];
    logic [31:0] ram_q;

    // ------------------------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------------------------
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

    w_state_e    w_state;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    id_t         bid_q;
    idx_t        w_idx_q;
    logic [7:0]  w_len_q;
    logic [8:0]  w_cnt_q;     // beats accepted, saturating at 256
    logic        w_decerr_q;

    logic        w_beat;
    logic        w_in_range;
    logic        mem_we;

    always_comb begin
        w_beat     = (w_state == WData) && s_axi.wvalid && wready_q;
        w_in_range = w_cnt_q <= {1'b0, w_len_q};
        mem_we     = w_beat && w_in_range && !w_decerr_q;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state    <= WIdle;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RespOkay;
            bid_q      <= '0;
            w_idx_q    <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_decerr_q <= 1'b0;
        end else begin
            unique case (w_state)
                WIdle: begin
                    if (awready_q && s_axi.awvalid) begin
                        bid_q      <= s_axi.awid;
                        w_idx_q    <= s_axi.awaddr[IdxW+1:2];
                        w_len_q    <= s_axi.awlen;
                        w_cnt_q    <= '0;
                        w_decerr_q <= addr_decerr(s_axi.awaddr);
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        w_state    <= WData;
                    end else begin
                        awready_q  <= 1'b1;
                    end
                end
                WData: begin
                    if (w_beat) begin
                        w_idx_q <= w_idx_q + idx_t'(1);
                        if (!w_cnt_q[8]) begin
                            w_cnt_q <= w_cnt_q + 9'd1;
                        end
                        if (s_axi.wlast) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            if (w_decerr_q) begin
                                bresp_q <= RespDecErr;
                            end else if (w_cnt_q != {1'b0, w_len_q}) begin
                                bresp_q <= RespSlvErr;  // WLAST early or late
                            end else begin
                                bresp_q <= RespOkay;
                            end
                            w_state <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state   <= WIdle;
                    end
                end
                default: w_state <= WIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------------------------
    // ram_q is the registered RAM output. It doubles as a prefetch stage (pf_*). A read is
    // issued into it only when it is empty or is draining into the output register this
    // cycle, so a stalled beat is never overwritten.
    typedef enum logic {RIdle, RData} r_state_e;

    r_state_e    r_state;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rlast_q;
    id_t         rid_q;
    idx_t        r_idx_q;
    logic [7:0]  r_len_q;
    logic [7:0]  r_cnt_q;     // beats issued to the RAM
    logic        r_all_q;     // every beat of the burst has been issued
    logic        r_decerr_q;
    logic        pf_valid_q;
    logic        pf_last_q;

    logic        r_out_free;
    logic        pf_move;
    logic        r_issue;

    always_comb begin
        r_out_free = !rvalid_q || s_axi.rready;
        pf_move    = pf_valid_q && r_out_free;
        r_issue    = (r_state == RData) && !r_all_q && (!pf_valid_q || r_out_free);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= RIdle;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RespOkay;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            r_idx_q    <= '0;
            r_len_q    <= '0;
            r_cnt_q    <= '0;
            r_all_q    <= 1'b0;
            r_decerr_q <= 1'b0;
            pf_valid_q <= 1'b0;
            pf_last_q  <= 1'b0;
        end else begin
            unique case (r_state)
                RIdle: begin
                    if (arready_q && s_axi.arvalid) begin
                        rid_q      <= s_axi.arid;
                        r_idx_q    <= s_axi.araddr[IdxW+1:2];
                        r_len_q    <= s_axi.arlen;
                        r_cnt_q    <= '0;
                        r_all_q    <= 1'b0;
                        r_decerr_q <= addr_decerr(s_axi.araddr);
                        arready_q  <= 1'b0;
                        r_state    <= RData;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                RData: begin
                    if (r_issue) begin
                        r_idx_q   <= r_idx_q + idx_t'(1);
                        r_cnt_q   <= r_cnt_q + 8'd1;
                        pf_last_q <= (r_cnt_q == r_len_q);
                        if (r_cnt_q == r_len_q) begin
                            r_all_q <= 1'b1;
                        end
                    end

                    if (r_issue) begin
                        pf_valid_q <= 1'b1;
                    end else if (pf_move) begin
                        pf_valid_q <= 1'b0;
                    end

                    if (pf_move) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= r_decerr_q ? 32'h0 : ram_q;
                        rresp_q  <= r_decerr_q ? RespDecErr : RespOkay;
                        rlast_q  <= pf_last_q;
                    end else if (rvalid_q && s_axi.rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            r_state   <= RIdle;
                        end
                    end
                end
                default: r_state <= RIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------------------------
    // RAM: one write port and one read port. A same-edge read of the word being written
    // returns the old contents.
    // ------------------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[w_idx_q][8*b +: 8] <= s_axi.wdata[8*b +: 8];
                end
            end
        end
        if (r_issue) begin
            ram_q <= mem[r_idx_q];
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.bid     = bid_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rid     = rid_q;
endmodule

// File: tb/tb_axi4_slave_bram.sv
// Directed bench for axi4_slave_bram.
// A table of write/read bursts carries hand-computed responses and data. Hand-written
// sequences cover reset behaviour and a reset that arrives in the middle of a burst.
module tb_axi4_slave_bram;
    localparam int Tmo = 200;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    axi4_slave_bram_if #(.C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32)) bus ();

    axi4_slave_bram #(
        .C_S_AXI_ID_WIDTH  (1),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_MEM_DEPTH_LOG2  (10)
    ) dut (
        .aclk  (aclk),
        .areset(areset),
        .s_axi (bus.slave)
    );

    // Writes send last_beat+1 beats with data + step*beat. Reads expect data + step*beat.
    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] data;
        logic [31:0] step;
        logic [3:0]  strb;
        int          last_beat;
        int          bdelay;
        bit          stall;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs[21];
    int   n_applied;
    int   n_miscompare;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] ctl_outs();
        return 32'({bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.bid,
                    bus.arready, bus.rvalid, bus.rlast, bus.rresp, bus.rid});
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, ctl_outs(), 32'h0);
        check({name, "_rdata"}, bus.rdata, 32'h0);
    endtask

    task automatic do_write(input vec_t v, input logic id);
        int cnt;
        bus.awid    = id;
        bus.awaddr  = v.addr;
        bus.awlen   = v.len;
        bus.awvalid = 1'b1;
        cnt = 0;
        while (!bus.awready && cnt < Tmo) begin tick(); cnt++; end
        check("awready_seen", 32'(bus.awready), 32'd1);
        tick();
        bus.awvalid = 1'b0;
        for (int b = 0; b <= v.last_beat; b++) begin
            bus.wdata  = v.data + v.step * 32'(b);
            bus.wstrb  = v.strb;
            bus.wlast  = (b == v.last_beat);
            bus.wvalid = 1'b1;
            cnt = 0;
            while (!bus.wready && cnt < Tmo) begin tick(); cnt++; end
            check("wready_seen", 32'(bus.wready), 32'd1);
            tick();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        cnt = 0;
        while (!bus.bvalid && cnt < Tmo) begin tick(); cnt++; end
        check("bvalid_seen", 32'(bus.bvalid), 32'd1);
        check("bresp", 32'(bus.bresp), 32'(v.resp));
        check("bid", 32'(bus.bid), 32'(id));
        for (int d = 0; d < v.bdelay; d++) begin
            tick();
            check("b_hold", 32'({bus.bvalid, bus.bresp, bus.bid}), 32'({1'b1, v.resp, id}));
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("b_done", 32'({bus.bvalid, bus.awready}), 32'b01);
    endtask

    task automatic do_read(input vec_t v, input logic id);
        int          cnt;
        int          beat;
        int          cyc;
        logic        stalled;
        logic [31:0] hold_data;
        logic [31:0] hold_ctl;
        bus.arid    = id;
        bus.araddr  = v.addr;
        bus.arlen   = v.len;
        bus.arvalid = 1'b1;
        cnt = 0;
        while (!bus.arready && cnt < Tmo) begin tick(); cnt++; end
        check("arready_seen", 32'(bus.arready), 32'd1);
        tick();
        bus.arvalid = 1'b0;
        // First RVALID lands two edges after the AR handshake edge
        cnt = 0;
        while (!bus.rvalid && cnt < Tmo) begin tick(); cnt++; end
        check("r_latency", 32'(cnt), 32'd2);
        beat      = 0;
        cyc       = 0;
        stalled   = 1'b0;
        hold_data = '0;
        hold_ctl  = '0;
        while (beat <= int'(v.len) && cyc < Tmo) begin
            bus.rready = v.stall ? (cyc % 3 == 0) : 1'b1;
            if (stalled) begin
                check("r_hold_data", bus.rdata, hold_data);
                check("r_hold_ctl", 32'({bus.rvalid, bus.rresp, bus.rlast, bus.rid}), hold_ctl);
            end
            if (bus.rvalid && bus.rready) begin
                check("rdata", bus.rdata, v.data + v.step * 32'(beat));
                check("rctl", 32'({bus.rresp, bus.rlast, bus.rid}),
                      32'({v.resp, beat == int'(v.len), id}));
                beat++;
                stalled = 1'b0;
            end else if (bus.rvalid) begin
                stalled   = 1'b1;
                hold_data = bus.rdata;
                hold_ctl  = 32'({bus.rvalid, bus.rresp, bus.rlast, bus.rid});
            end else begin
                stalled = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.rready = 1'b0;
        check("r_beats", 32'(beat), 32'(v.len) + 32'd1);
        if (!v.stall) begin
            check("r_b2b_cycles", 32'(cyc), 32'(v.len) + 32'd1);
        end
        check("r_done", 32'({bus.rvalid, bus.arready}), 32'b01);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        n_applied    = 0;
        n_miscompare = 0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        areset = 1'b1;

        //          wr    addr           len   data           step           strb  lb bd st resp
        vecs[0]  = '{1'b1, 32'h0000_0100, 8'd4, 32'h1234_5678, 32'd1,         4'hF, 4, 0, 0, 2'b00};
        vecs[1]  = '{1'b0, 32'h0000_0100, 8'd4, 32'h1234_5678, 32'd1,         4'h0, 0, 0, 0, 2'b00};
        vecs[2]  = '{1'b1, 32'h0000_0200, 8'd0, 32'h1122_3344, 32'd0,         4'hF, 0, 3, 0, 2'b00};
        vecs[3]  = '{1'b0, 32'h0000_0200, 8'd0, 32'h1122_3344, 32'd0,         4'h0, 0, 0, 0, 2'b00};
        vecs[4]  = '{1'b1, 32'h0000_0300, 8'd0, 32'hFFFF_FFFF, 32'd0,         4'hF, 0, 0, 0, 2'b00};
        vecs[5]  = '{1'b1, 32'h0000_0300, 8'd0, 32'h0000_00AA, 32'd0,         4'h1, 0, 0, 0, 2'b00};
        vecs[6]  = '{1'b0, 32'h0000_0300, 8'd0, 32'hFFFF_FFAA, 32'd0,         4'h0, 0, 0, 0, 2'b00};
        vecs[7]  = '{1'b0, 32'h0000_0100, 8'd4, 32'h1234_5678, 32'd1,         4'h0, 0, 0, 1, 2'b00};
        vecs[8]  = '{1'b1, 32'h0000_0000, 8'd1, 32'hA5A5_A5A5, 32'd1,         4'hF, 1, 0, 0, 2'b00};
        vecs[9]  = '{1'b1, 32'h0000_4000, 8'd1, 32'hDEAD_0000, 32'd1,         4'hF, 1, 0, 0, 2'b11};
        vecs[10] = '{1'b0, 32'h0000_4000, 8'd1, 32'h0000_0000, 32'd0,         4'h0, 0, 0, 0, 2'b11};
        vecs[11] = '{1'b0, 32'h0000_0000, 8'd1, 32'hA5A5_A5A5, 32'd1,         4'h0, 0, 0, 0, 2'b00};
        vecs[12] = '{1'b1, 32'h0000_0000, 8'd3, 32'hBEEF_0000, 32'd1,         4'hF, 2, 0, 0, 2'b10};
        vecs[13] = '{1'b0, 32'h0000_0000, 8'd2, 32'hBEEF_0000, 32'd1,         4'h0, 0, 0, 0, 2'b00};
        vecs[14] = '{1'b1, 32'h0000_0504, 8'd0, 32'h7777_7777, 32'd0,         4'hF, 0, 0, 0, 2'b00};
        vecs[15] = '{1'b1, 32'h0000_0500, 8'd0, 32'h5555_0000, 32'd1,         4'hF, 1, 0, 0, 2'b10};
        vecs[16] = '{1'b0, 32'h0000_0500, 8'd0, 32'h5555_0000, 32'd0,         4'h0, 0, 0, 0, 2'b00};
        vecs[17] = '{1'b0, 32'h0000_0504, 8'd0, 32'h7777_7777, 32'd0,         4'h0, 0, 0, 0, 2'b00};
        vecs[18] = '{1'b1, 32'h0000_0FFC, 8'd1, 32'hCAFE_0000, 32'd1,         4'hF, 1, 0, 0, 2'b00};
        vecs[19] = '{1'b0, 32'h0000_0FFC, 8'd1, 32'hCAFE_0000, 32'd1,         4'h0, 0, 0, 0, 2'b00};
        vecs[20] = '{1'b0, 32'h0000_0000, 8'd0, 32'hCAFE_0001, 32'd0,         4'h0, 0, 0, 0, 2'b00};

        // Reset state, then ready on the first edge after release
        repeat (3) tick();
        check_all_zero("reset");
        areset = 1'b0;
        check("ready_before_edge", 32'({bus.awready, bus.arready}), 32'b00);
        tick();
        check("ready_after_release", 32'({bus.awready, bus.arready}), 32'b11);

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i], i[0]);
            end else begin
                do_read(vecs[i], i[0]);
            end
        end

        // Reset in the middle of a write burst, with a stalled read in flight as well
        bus.arid = 1'b1; bus.araddr = 32'h100; bus.arlen = 8'd4; bus.arvalid = 1'b1;
        bus.awid = 1'b1; bus.awaddr = 32'h600; bus.awlen = 8'd3; bus.awvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        bus.wdata = 32'h0000_0001; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        tick();
        tick();
        check("mid_rvalid_pending", 32'(bus.rvalid), 32'd1);
        areset = 1'b1;
        #1;
        check_all_zero("reset_mid");
        bus.wvalid = 1'b0;
        tick();
        check_all_zero("reset_mid_held");
        areset = 1'b0;
        check("mid_no_resp", 32'({bus.bvalid, bus.rvalid, bus.awready}), 32'b000);
        tick();
        check("mid_ready_back", 32'({bus.awready, bus.arready, bus.bvalid, bus.rvalid}),
              32'b1100);
        v = '{1'b1, 32'h0000_0600, 8'd0, 32'h600D_F00D, 32'd0, 4'hF, 0, 0, 0, 2'b00};
        do_write(v, 1'b0);
        v.is_wr = 1'b0;
        do_read(v, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end
endmodule
